mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Data-memory side of the control path. Consumes memren/memwren/funct3 from decode plus
//  ALU address and rs2 data from execute, drives a req/gnt/rvalid data-memory port, and
//  returns load data aligned and extended for writeback.
//  Multi-cycle FSM; stalls the pipeline via stall_o until the access completes.
// PARAMETERS
//  AWIDTH  32  address width (ALU result)
//  DWIDTH  32  data width; byte-enable width is DWIDTH/8 (4)
// PORTS
//  clk           in   1       single clock, all state on rising edge
//  reset         in   1       synchronous, active-high
//  req_valid_i   in   1       execute presents a memory op this cycle
//  req_ready_o   out  1       unit can accept (state==IDLE && !reset)
//  memren_i      in   1       load (from control)
//  memwren_i     in   1       store (from control); wins if both set
//  funct3_i      in   3       LB/LH/LW/LBU/LHU, SB/SH/SW
//  addr_i        in   AWIDTH  byte address (rs1+imm)
//  wdata_i       in   DWIDTH  store data (rs2)
//  mem_req_o     out  1       memory request, held until mem_gnt_i
//  mem_we_o      out  1       1=write
//  mem_addr_o    out  AWIDTH  {addr[AWIDTH-1:2],2'b00}
//  mem_wdata_o   out  DWIDTH  store data shifted to byte lane
//  mem_be_o      out  4       byte enables
//  mem_gnt_i     in   1       request accepted
//  mem_rvalid_i  in   1       read data valid
//  mem_rdata_i   in   DWIDTH  raw read word
//  rsp_valid_o   out  1       1-cycle completion pulse
//  rsp_rdata_o   out  DWIDTH  extended load data (0 for stores/faults)
//  fault_o       out  1       1-cycle pulse with rsp_valid_o on misaligned/illegal op
//  stall_o       out  1       freeze upstream stages
// BEHAVIOUR
//  Reset: state=IDLE; mem_req_o, mem_we_o, rsp_valid_o, fault_o, stall_o, req_ready_o=0;
//   mem_addr_o/wdata/be/rsp_rdata_o=0. Reset mid-access abandons it; mem_req_o low next
//   cycle; rvalid arriving in IDLE is ignored.
//  States: IDLE, REQ, WAIT_RD, RESP.
//  Accept: req_valid_i && req_ready_o && (memren_i|memwren_i); capture addr, funct3,
//   offset=addr[1:0], we=memwren_i, lane data. No mem op -> no accept, stay IDLE.
//  Fault check at accept: H with off[0]=1, W with off!=0, load funct3 in {3,6,7}, store
//   funct3>2 -> IDLE->RESP directly, no mem_req_o; RESP pulses fault_o, rsp_rdata_o=0.
//  Store lanes: SB be=4'b0001<<off, wdata[7:0]<<8*off; SH be=4'b0011<<off,
//   wdata[15:0]<<8*off; SW be=4'b1111. Loads drive be=4'b1111.
//  IDLE->REQ on good accept. REQ: mem_req_o=1, outputs stable until gnt.
//   gnt & store -> RESP; gnt & load -> WAIT_RD. rvalid sampled only in WAIT_RD (>=1 cycle
//   after gnt). WAIT_RD: on rvalid latch extracted data -> RESP.
//  Extract: byte=rdata>>8*off; LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW as is.
//  RESP: rsp_valid_o=1 one cycle -> IDLE.
//  stall_o = accept | state in {REQ,WAIT_RD}; low in RESP so pipeline advances with data.
//  Min latency (gnt and rvalid immediate): store accept N, req N+1, rsp N+2;
//   load accept N, req/gnt N+1, rvalid N+2, rsp N+3.
// STRUCTURE
//  Shared package (constants.svh): FUNCT3_LB..FUNCT3_LHU, FUNCT3_SB..FUNCT3_SW,
//   typedef enum mau_state_e {IDLE,REQ,WAIT_RD,RESP}.
//  Sub-module load_align: combinational (rdata, off, funct3) -> extended word; reusable
//   by a future cache.
// TESTING
//  SW addr=0x100, wdata=0xDEADBEEF, gnt immediate -> mem_addr=0x100, be=1111, rsp@N+2.
//  SB addr=0x103, wdata=0x000000A5 -> be=1000, mem_wdata=0xA5000000, mem_we=1.
//  LB addr=0x102, rdata=0x00800000 -> rsp_rdata=0xFFFFFF80; LBU same -> 0x00000080.
//  LW addr=0x102 -> no mem_req_o, fault_o=1 with rsp_valid_o, rsp_rdata=0.
//  LH, gnt delayed 3 cycles, rvalid 2 after gnt -> mem_req_o held 4 cycles, stall_o high
//   throughout, single rsp_valid_o pulse.
//  reset during WAIT_RD, then rvalid -> IDLE, no rsp_valid_o, req_ready_o=1 after reset.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the data-memory access unit: funct3 encodings,
// FSM state enum and the accept-time fault check.
package mem_access_unit_pkg;

    localparam int unsigned MAU_AWIDTH = 32;
    localparam int unsigned MAU_DWIDTH = 32;

    localparam logic [2:0] FUNCT3_LB  = 3'd0;
    localparam logic [2:0] FUNCT3_LH  = 3'd1;
    localparam logic [2:0] FUNCT3_LW  = 3'd2;
    localparam logic [2:0] FUNCT3_LBU = 3'd4;
    localparam logic [2:0] FUNCT3_LHU = 3'd5;
    localparam logic [2:0] FUNCT3_SB  = 3'd0;
    localparam logic [2:0] FUNCT3_SH  = 3'd1;
    localparam logic [2:0] FUNCT3_SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } mau_state_e;

    // Illegal funct3 for the op type, or a half/word access off its natural alignment.
    function automatic logic op_fault(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] off);
        logic bad_op;
        logic misaligned;
        bad_op     = is_store ? (f3 > FUNCT3_SW) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        misaligned = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
        return bad_op || misaligned;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/gnt/rvalid port; master is the access unit, slave is the memory.
interface mem_access_unit_if
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned AWIDTH = MAU_AWIDTH,
    parameter int unsigned DWIDTH = MAU_DWIDTH
) ();
    logic                  req;
    logic                  we;
    logic [AWIDTH-1:0]     addr;
    logic [DWIDTH-1:0]     wdata;
    logic [DWIDTH/8-1:0]   be;
    logic                  gnt;
    logic                  rvalid;
    logic [DWIDTH-1:0]     rdata;

    modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Combinational load extraction: shift the raw word to the accessed byte lane and
// sign/zero-extend by funct3. Kept standalone so a cache can reuse it.
module mem_access_unit_load_align
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DWIDTH = MAU_DWIDTH
) (
    input  logic [DWIDTH-1:0] rdata_i,
    input  logic [1:0]        off_i,
    input  logic [2:0]        funct3_i,
    output logic [DWIDTH-1:0] data_c_o
);
    logic [DWIDTH-1:0] shifted;

    always_comb begin
        shifted  = rdata_i >> {off_i, 3'b000};
        data_c_o = '0;
        case (funct3_i)
            FUNCT3_LB:  data_c_o = {{(DWIDTH-8){shifted[7]}}, shifted[7:0]};
            FUNCT3_LH:  data_c_o = {{(DWIDTH-16){shifted[15]}}, shifted[15:0]};
            FUNCT3_LW:  data_c_o = shifted;
            FUNCT3_LBU: data_c_o = DWIDTH'(shifted[7:0]);
            FUNCT3_LHU: data_c_o = DWIDTH'(shifted[15:0]);
            default:    data_c_o = '0;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: accepts one load/store from execute, runs it on the
// req/gnt/rvalid port and returns aligned load data, stalling the pipeline meanwhile.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned AWIDTH = MAU_AWIDTH,
    parameter int unsigned DWIDTH = MAU_DWIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                memren_i,
    input  logic                memwren_i,
    input  logic [2:0]          funct3_i,
    input  logic [AWIDTH-1:0]   addr_i,
    input  logic [DWIDTH-1:0]   wdata_i,
    mem_access_unit_if.master   mem,
    output logic                rsp_valid_o,
    output logic [DWIDTH-1:0]   rsp_rdata_o,
    output logic                fault_o,
    output logic                stall_o
);
    localparam int unsigned BEW = DWIDTH / 8;

    mau_state_e        state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic              we_q, we_d;
    logic              bad_q, bad_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [BEW-1:0]    be_q, be_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              req_q, req_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              fault_q, fault_d;
    logic              accept_c;
    logic [4:0]        lane_sh_c;
    logic [DWIDTH-1:0] ext_c;

    assign req_ready_o = (state_q == IDLE) && !reset;
    assign accept_c    = req_valid_i && req_ready_o && (memren_i || memwren_i);
    assign stall_o     = accept_c || (state_q == REQ) || (state_q == WAIT_RD);
    assign lane_sh_c   = {addr_i[1:0], 3'b000};

    mem_access_unit_load_align #(.DWIDTH(DWIDTH)) u_load_align (
        .rdata_i  (mem.rdata),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_c_o (ext_c)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        f3_d    = f3_q;
        we_d    = we_q;
        bad_d   = bad_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    addr_d  = {addr_i[AWIDTH-1:2], 2'b00};
                    off_d   = addr_i[1:0];
                    f3_d    = funct3_i;
                    we_d    = memwren_i;
                    bad_d   = op_fault(memwren_i, funct3_i, addr_i[1:0]);
                    rdata_d = '0;
                    be_d    = {BEW{1'b1}};
                    wdata_d = '0;
                    if (memwren_i) begin
                        // Sub-word stores are steered onto their byte lanes here.
                        case (funct3_i)
                            FUNCT3_SB: begin
                                be_d    = BEW'(1'b1) << addr_i[1:0];
                                wdata_d = DWIDTH'(wdata_i[7:0]) << lane_sh_c;
                            end
                            FUNCT3_SH: begin
                                be_d    = BEW'(2'b11) << addr_i[1:0];
                                wdata_d = DWIDTH'(wdata_i[15:0]) << lane_sh_c;
                            end
                            default: wdata_d = wdata_i;
                        endcase
                    end
                    state_d = bad_d ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem.gnt) state_d = we_q ? RESP : WAIT_RD;
            end
            WAIT_RD: begin
                if (mem.rvalid) begin
                    rdata_d = ext_c;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_d       = (state_d == REQ);
        rsp_valid_d = (state_d == RESP);
        fault_d     = (state_d == RESP) && bad_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            off_q       <= '0;
            f3_q        <= '0;
            we_q        <= 1'b0;
            bad_q       <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
            req_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            we_q        <= we_d;
            bad_q       <= bad_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            fault_q     <= fault_d;
        end
    end

    assign mem.req     = req_q;
    assign mem.we      = we_q;
    assign mem.addr    = addr_q;
    assign mem.wdata   = wdata_q;
    assign mem.be      = be_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign fault_o     = fault_q;
endmodule
